risc_fetch_ctrl: RTL and testbench

Instruction-fetch and memory-sharing controller for the Simple RISC Machine. Owns the program counter and instruction register, fetches 16-bit instructions from the shared single-port RAM, and hands each one to the datapath FSM via its `s`/`w` handshake. While an instruction executes, it arbitrates the same RAM port for datapath load/store requests. Sits between the RAM and the datapath FSM.

---
 rtl/risc_pkg.sv | 26 ++
 rtl/risc_fetch_ctrl_if.sv | 39 +++
 rtl/risc_pc.sv | 28 ++
 rtl/risc_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_risc_fetch_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the Simple RISC Machine fetch controller.
package risc_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IF1   = 3'd1,
        S_IF2   = 3'd2,
        S_UPD   = 3'd3,
        S_DEC   = 3'd4,
        S_EXEC  = 3'd5,
        S_HALT  = 3'd6,
        S_FAULT = 3'd7
    } fetch_state_t;

    function automatic logic is_halt(input logic [2:0] opcode);
        return (opcode == OP_HALT);
    endfunction

endpackage

// File: rtl/risc_fetch_ctrl_if.sv
// Bundle of RAM-port and datapath handshake signals around the fetch controller.
interface risc_fetch_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              run;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic              dp_s;
    logic              dp_w;
    logic              dp_mem_rd;
    logic              dp_mem_wr;
    logic [ADDR_W-1:0] dp_addr;
    logic [DATA_W-1:0] dp_wdata;
    logic              dp_rvalid;
    logic              dp_pc_load;
    logic [ADDR_W-1:0] dp_pc_target;
    logic              halted;
    logic              fault;

    modport master (
        input  run, mem_rdata, dp_w, dp_mem_rd, dp_mem_wr, dp_addr, dp_wdata,
               dp_pc_load, dp_pc_target,
        output mem_addr, mem_rd, mem_wr, mem_wdata, ir, pc, dp_s, dp_rvalid,
               halted, fault
    );

    modport slave (
        output run, mem_rdata, dp_w, dp_mem_rd, dp_mem_wr, dp_addr, dp_wdata,
               dp_pc_load, dp_pc_target,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, ir, pc, dp_s, dp_rvalid,
               halted, fault
    );
endinterface

// File: rtl/risc_pc.sv
// Program counter: async active-low reset, branch load has priority over increment.
module risc_pc
    import risc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc
);
    logic [ADDR_W-1:0] r_pc;

    // PC register; increment wraps naturally at the top of the address space
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/risc_fetch_ctrl.sv
// Instruction fetch and RAM-sharing controller for the Simple RISC Machine.
// Optional execution watchdog: define RISC_FETCH_TIMEOUT_EN.
module risc_fetch_ctrl
    import risc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef RISC_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    risc_fetch_ctrl_if.master  bus
);
    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [DATA_W-1:0] r_ir;
    logic              r_dp_rvalid;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_dp_s;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic              w_ir_load;
    logic              w_grant_rd;

    risc_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_inc    (w_pc_inc),
        .i_load   (w_pc_load),
        .i_target (bus.dp_pc_target),
        .o_pc     (w_pc)
    );

`ifdef RISC_FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_to_cnt;

    // Watchdog: cleared in DEC so every EXEC entry starts at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == S_DEC) begin
            r_to_cnt <= 8'd0;
        end else if ((r_state == S_EXEC) && !bus.dp_w) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and RAM port arbitration
    always_comb begin
        w_next     = r_state;
        w_mem_addr = w_pc;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_dp_s     = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_ir_load  = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) w_next = S_IF1;
                else         w_next = S_IDLE;
            end
            S_IF1: begin
                w_mem_rd = 1'b1;
                w_next   = S_IF2;
            end
            S_IF2: begin
                w_ir_load = 1'b1;
                w_next    = S_UPD;
            end
            S_UPD: begin
                w_pc_inc = 1'b1;
                w_next   = S_DEC;
            end
            S_DEC: begin
                if (is_halt(r_ir[DATA_W-1 -: 3])) begin
                    w_next = S_HALT;
                end else if (!bus.run) begin
                    w_next = S_IDLE;
                end else begin
                    w_dp_s = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Datapath owns the RAM port; a simultaneous write beats the read
                w_mem_addr = bus.dp_addr;
                w_mem_wr   = bus.dp_mem_wr;
                w_mem_rd   = bus.dp_mem_rd & ~bus.dp_mem_wr;
                w_grant_rd = bus.dp_mem_rd & ~bus.dp_mem_wr;
                w_pc_load  = bus.dp_pc_load;
                if (bus.dp_w) begin
                    w_next = S_IF1;
                end
`ifdef RISC_FETCH_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_next = S_FAULT;
                end
`endif
                else begin
                    w_next = S_EXEC;
                end
            end
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    // Instruction register and read-valid flag for datapath loads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir        <= '0;
            r_dp_rvalid <= 1'b0;
        end else begin
            if (w_ir_load) r_ir <= bus.mem_rdata;
            r_dp_rvalid <= w_grant_rd;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_wdata = bus.dp_wdata;
    assign bus.ir        = r_ir;
    assign bus.pc        = w_pc;
    assign bus.dp_s      = w_dp_s;
    assign bus.dp_rvalid = r_dp_rvalid;
    assign bus.halted    = (r_state == S_HALT);
`ifdef RISC_FETCH_TIMEOUT_EN
    assign bus.fault     = (r_state == S_FAULT);
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_risc_fetch_ctrl.sv
// Scoreboard bench for risc_fetch_ctrl with a behavioural single-port RAM.
module tb_risc_fetch_ctrl;
    import risc_pkg::*;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    logic [8:0]  addr_q [$];
    logic [15:0] rdat_q [$];
    logic [15:0] ram [0:511];

    risc_fetch_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    risc_fetch_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read, data valid the cycle after mem_rd
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic apply_reset();
        reset_n          = 1'b0;
        bus.run          = 1'b0;
        bus.dp_w         = 1'b1;
        bus.dp_mem_rd    = 1'b0;
        bus.dp_mem_wr    = 1'b0;
        bus.dp_addr      = 9'h000;
        bus.dp_wdata     = 16'h0000;
        bus.dp_pc_load   = 1'b0;
        bus.dp_pc_target = 9'h000;
        addr_q.delete();
        rdat_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for IF1, checks fetch address and the IF2/UPD/DEC sequence; returns in EXEC cycle 1
    task automatic fetch_seq(input string tag, input logic [15:0] exp_ir, input logic [8:0] exp_pc);
        int n;
        logic [8:0] ea;
        #1;
        n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL %s_if1_wait: mem_rd=%b required 1", tag, bus.mem_rd);
        end
        ea = addr_q.pop_front();
        checks++;
        if (bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL %s_if1_addr: mem_addr=%h required %h", tag, bus.mem_addr, ea);
        end
        checks++;
        if (bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL %s_if1_wr: mem_wr=%b required 0", tag, bus.mem_wr);
        end
        bus.dp_pc_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ir !== exp_ir) begin
            errors++;
            $display("FAIL %s_ir: ir=%h required %h", tag, bus.ir, exp_ir);
        end
        @(negedge clk);
        checks++;
        if (bus.pc !== exp_pc) begin
            errors++;
            $display("FAIL %s_pc: pc=%h required %h", tag, bus.pc, exp_pc);
        end
        checks++;
        if (bus.dp_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_dp_s_dec: dp_s=%b required 1", tag, bus.dp_s);
        end
        bus.dp_w = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dp_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_dp_s_exec: dp_s=%b required 0", tag, bus.dp_s);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.pc, bus.ir, bus.mem_addr} !== {9'h000, 16'h0000, 9'h000}) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h addr=%h required 0", bus.pc, bus.ir, bus.mem_addr);
        end
        checks++;
        if ({bus.mem_rd, bus.mem_wr, bus.dp_s, bus.dp_rvalid, bus.halted, bus.fault} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_bits: rd/wr/s/rv/h/f=%b required 000000",
                     {bus.mem_rd, bus.mem_wr, bus.dp_s, bus.dp_rvalid, bus.halted, bus.fault});
        end
        release_reset();
    endtask

    // First MOV fetch, then three busy EXEC cycles before the datapath returns to WAIT
    task automatic test_first_fetch();
        bus.run = 1'b1;
        addr_q.push_back(9'h000);
        fetch_seq("mov", 16'hD105, 9'h001);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.dp_s !== 1'b0 || bus.mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL exec_quiet: dp_s=%b mem_rd=%b required 0 0", bus.dp_s, bus.mem_rd);
            end
        end
        bus.dp_w = 1'b1;
        addr_q.push_back(9'h001);
    endtask

    task automatic test_mem_arb();
        fetch_seq("alu", 16'hA000, 9'h002);
        bus.dp_mem_wr = 1'b1;
        bus.dp_addr   = 9'h040;
        bus.dp_wdata  = 16'hBEEF;
        #1;
        checks++;
        if ({bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {1'b1, 9'h040, 16'hBEEF}) begin
            errors++;
            $display("FAIL dp_write: wr=%b addr=%h wdata=%h required 1 040 beef",
                     bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.dp_mem_wr = 1'b0;
        bus.dp_mem_rd = 1'b1;
        rdat_q.push_back(16'hBEEF);
        #1;
        checks++;
        if (bus.mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL dp_read_grant: mem_rd=%b required 1", bus.mem_rd);
        end
        @(negedge clk);
        checks++;
        if (bus.dp_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL dp_rvalid: dp_rvalid=%b required 1", bus.dp_rvalid);
        end
        checks++;
        if (bus.mem_rdata !== rdat_q[0]) begin
            errors++;
            $display("FAIL dp_rdata: mem_rdata=%h required %h", bus.mem_rdata, rdat_q[0]);
        end
        void'(rdat_q.pop_front());
        bus.dp_mem_wr = 1'b1;
        bus.dp_addr   = 9'h041;
        bus.dp_wdata  = 16'h1234;
        #1;
        checks++;
        if ({bus.mem_rd, bus.mem_wr} !== 2'b01) begin
            errors++;
            $display("FAIL write_wins: rd/wr=%b required 01", {bus.mem_rd, bus.mem_wr});
        end
        @(negedge clk);
        checks++;
        if (bus.dp_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_after_write: dp_rvalid=%b required 0", bus.dp_rvalid);
        end
        checks++;
        if (ram[9'h041] !== 16'h1234) begin
            errors++;
            $display("FAIL ram_41: ram=%h required 1234", ram[9'h041]);
        end
        bus.dp_mem_rd    = 1'b0;
        bus.dp_mem_wr    = 1'b0;
        bus.dp_pc_load   = 1'b1;
        bus.dp_pc_target = 9'h1FF;
        bus.dp_w         = 1'b1;
        addr_q.push_back(9'h1FF);
    endtask

    task automatic test_wrap_branch();
        fetch_seq("wrap", 16'hD1FF, 9'h000);
        bus.dp_pc_load   = 1'b1;
        bus.dp_pc_target = 9'h020;
        @(negedge clk);
        checks++;
        if (bus.pc !== 9'h020) begin
            errors++;
            $display("FAIL branch_first: pc=%h required 020", bus.pc);
        end
        bus.dp_pc_target = 9'h010;
        @(negedge clk);
        checks++;
        if (bus.pc !== 9'h010) begin
            errors++;
            $display("FAIL branch_last: pc=%h required 010", bus.pc);
        end
        bus.dp_pc_load = 1'b0;
        bus.dp_w       = 1'b1;
        addr_q.push_back(9'h010);
    endtask

    task automatic test_halt();
        int n;
        logic [8:0] ea;
        bit saw_s, saw_wr, saw_rd, lost_h;
        #1;
        n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ea = addr_q.pop_front();
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL halt_if1: rd=%b addr=%h required 1 %h", bus.mem_rd, bus.mem_addr, ea);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dp_s !== 1'b0) begin
            errors++;
            $display("FAIL halt_dec_s: dp_s=%b required 0", bus.dp_s);
        end
        bus.dp_mem_wr = 1'b1;
        bus.dp_addr   = 9'h060;
        bus.dp_wdata  = 16'hFFFF;
        saw_s = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0; lost_h = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dp_s !== 1'b0) saw_s = 1'b1;
            if (bus.mem_wr !== 1'b0) saw_wr = 1'b1;
            if (bus.mem_rd !== 1'b0) saw_rd = 1'b1;
            if (bus.halted !== 1'b1) lost_h = 1'b1;
        end
        checks++;
        if (lost_h) begin
            errors++;
            $display("FAIL halted_hold: halted dropped, required 1 throughout");
        end
        checks++;
        if ({saw_s, saw_wr, saw_rd} !== 3'b000) begin
            errors++;
            $display("FAIL halt_quiet: s/wr/rd seen=%b required 000", {saw_s, saw_wr, saw_rd});
        end
        checks++;
        if (ram[9'h060] !== 16'h0000) begin
            errors++;
            $display("FAIL halt_no_write: ram=%h required 0000", ram[9'h060]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b required 0", bus.halted);
        end
    endtask

    // run dropped mid-EXEC still lets the next fetch finish, then parks in IDLE
    task automatic test_run_drop();
        int n;
        logic [8:0] ea;
        apply_reset();
        release_reset();
        bus.run = 1'b1;
        addr_q.push_back(9'h000);
        fetch_seq("rd0", 16'hD105, 9'h001);
        bus.run  = 1'b0;
        bus.dp_w = 1'b1;
        addr_q.push_back(9'h001);
        #1;
        n = 0;
        while (bus.mem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ea = addr_q.pop_front();
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL rundrop_if1: rd=%b addr=%h required 1 %h", bus.mem_rd, bus.mem_addr, ea);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dp_s !== 1'b0) begin
            errors++;
            $display("FAIL rundrop_dp_s: dp_s=%b required 0", bus.dp_s);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_rd, bus.pc} !== {1'b0, 9'h002}) begin
            errors++;
            $display("FAIL rundrop_idle: rd=%b pc=%h required 0 002", bus.mem_rd, bus.pc);
        end
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        release_reset();
        bus.run = 1'b1;
        addr_q.push_back(9'h000);
        fetch_seq("rst", 16'hD105, 9'h001);
        bus.dp_mem_wr = 1'b1;
        bus.dp_addr   = 9'h050;
        bus.dp_wdata  = 16'h5555;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_wr, bus.mem_addr, bus.pc, bus.ir} !== {1'b0, 9'h000, 9'h000, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: wr=%b addr=%h pc=%h ir=%h required 0 000 000 0000",
                     bus.mem_wr, bus.mem_addr, bus.pc, bus.ir);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram[9'h050] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_no_write: ram=%h required 0000", ram[9'h050]);
        end
        bus.dp_mem_wr = 1'b0;
        bus.run       = 1'b0;
        release_reset();
    endtask

    task automatic test_timeout();
        int n;
        bit bad;
        bus.run = 1'b1;
        addr_q.push_back(9'h000);
        fetch_seq("to", 16'hD105, 9'h001);
`ifdef RISC_FETCH_TIMEOUT_EN
        n = 1;
        while (bus.fault !== 1'b1 && n < 400) begin
            @(negedge clk);
            if (bus.fault !== 1'b1) n++;
        end
        checks++;
        if (bus.fault !== 1'b1 || n != 255) begin
            errors++;
            $display("FAIL timeout: fault=%b exec_cycles=%0d required 1 255", bus.fault, n);
        end
`else
        bad = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.fault !== 1'b0 || bus.mem_rd !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_timeout: fault or refetch seen, required EXEC wait");
        end
`endif
        apply_reset();
        release_reset();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        ram[9'h000] = {OP_MOV, 13'h1105};
        ram[9'h001] = {OP_ALU, 13'h0000};
        ram[9'h010] = {OP_HALT, 13'h0000};
        ram[9'h1FF] = 16'hD1FF;
        test_reset();
        test_first_fetch();
        test_mem_arb();
        test_wrap_branch();
        test_halt();
        test_run_drop();
        test_reset_mid_exec();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
